// File: rtl/kbd_key_if.sv
// kbd_key_if: bundle between the PS/2 byte receiver, the scan-code
// controller and the game logic.
//
// Handshake: din is a valid byte only in a cycle where din_new=1. There is
// no ready; the controller accepts every strobe, including strobes on
// consecutive cycles. All outputs are registered. key_press, key_release,
// code_valid and err are single-cycle pulses. key_down is a level.
//
// Signals:
//   din[7:0]         received byte, valid with din_new
//   din_new          one-cycle strobe for din
//   key_down[3:0]    held state of each game key
//   key_press[3:0]   key went up->down (pulse)
//   key_release[3:0] key went down->up (pulse)
//   code_out[9:0]    {brk, ext, code} of the last complete sequence
//   code_valid       code_out updated (pulse)
//   err              dangling-prefix timeout or 0x00/0xFF byte (pulse)
//   state_dbg[1:0]   parser state, for observation only
interface kbd_key_if;
  logic [7:0] din;
  logic       din_new;
  logic [3:0] key_down;
  logic [3:0] key_press;
  logic [3:0] key_release;
  logic [9:0] code_out;
  logic       code_valid;
  logic       err;
  logic [1:0] state_dbg;

  modport master (
    output din, din_new,
    input  key_down, key_press, key_release, code_out, code_valid, err,
           state_dbg
  );

  modport slave (
    input  din, din_new,
    output key_down, key_press, key_release, code_out, code_valid, err,
           state_dbg
  );
endinterface

// File: rtl/kbd_key_ctrl.sv
// kbd_key_ctrl: PS/2 Set-2 scan-code parser for four game keys.
// Parses make, break (0xF0) and extended (0xE0) sequences, tracks the held
// state of four configured keys and emits registered press/release pulses.
// A timeout returns the parser to idle when a prefix byte is left dangling.
//
// Ports:
//   clk    system clock
//   reset  asynchronous, active-high reset
//   bus    kbd_key_if slave modport (byte input, key/code/err outputs)
module kbd_key_ctrl #(
  parameter logic [7:0] KEY0_CODE      = 8'h12,
  parameter logic       KEY0_EXT       = 1'b0,
  parameter logic [7:0] KEY1_CODE      = 8'h59,
  parameter logic       KEY1_EXT       = 1'b0,
  parameter logic [7:0] KEY2_CODE      = 8'h29,
  parameter logic       KEY2_EXT       = 1'b0,
  parameter logic [7:0] KEY3_CODE      = 8'h5A,
  parameter logic       KEY3_EXT       = 1'b0,
  parameter int         TIMEOUT_CYCLES = 2_500_000
) (
  input  logic      clk,
  input  logic      reset,
  kbd_key_if.slave  bus
);

  localparam int CW = ($clog2(TIMEOUT_CYCLES) < 1) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  localparam logic [3:0][7:0] KEY_CODES = {KEY3_CODE, KEY2_CODE, KEY1_CODE, KEY0_CODE};
  localparam logic [3:0]      KEY_EXTS  = {KEY3_EXT, KEY2_EXT, KEY1_EXT, KEY0_EXT};

  typedef enum logic [1:0] {
    WAIT_ST = 2'd0,
    EXT_ST  = 2'd1,
    BRK_ST  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          ext_q, ext_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    key_down_q, key_down_d;
  logic [3:0]    key_press_q, key_press_d;
  logic [3:0]    key_release_q, key_release_d;
  logic [9:0]    code_out_q, code_out_d;
  logic          code_valid_q, code_valid_d;
  logic          err_q, err_d;

  // Decoded properties of a completed sequence in this cycle.
  logic complete;
  logic brk;
  logic ext_use;

  always_comb begin
    state_d       = state_q;
    ext_d         = ext_q;
    cnt_d         = cnt_q;
    key_down_d    = key_down_q;
    key_press_d   = '0;
    key_release_d = '0;
    code_out_d    = code_out_q;
    code_valid_d  = 1'b0;
    err_d         = 1'b0;
    complete      = 1'b0;
    brk           = 1'b0;
    ext_use       = ext_q;

    if (bus.din_new) begin
      cnt_d = '0;
      // Line-noise bytes abort any sequence regardless of state.
      if (bus.din == 8'h00 || bus.din == 8'hFF) begin
        err_d   = 1'b1;
        ext_d   = 1'b0;
        state_d = WAIT_ST;
      end else begin
        unique case (state_q)
          WAIT_ST: begin
            if (bus.din == 8'hE0) begin
              state_d = EXT_ST;
              ext_d   = 1'b1;
            end else if (bus.din == 8'hF0) begin
              state_d = BRK_ST;
              ext_d   = 1'b0;
            end else begin
              complete = 1'b1;
              ext_use  = 1'b0;
            end
          end
          EXT_ST: begin
            if (bus.din == 8'hF0) begin
              state_d = BRK_ST;
            end else if (bus.din == 8'hE0) begin
              state_d = EXT_ST;
            end else begin
              complete = 1'b1;
              ext_use  = 1'b1;
              ext_d    = 1'b0;
              state_d  = WAIT_ST;
            end
          end
          BRK_ST: begin
            state_d = WAIT_ST;
            ext_d   = 1'b0;
            if (bus.din == 8'hE0 || bus.din == 8'hF0) begin
              err_d = 1'b1;
            end else begin
              complete = 1'b1;
              brk      = 1'b1;
              ext_use  = ext_q;
            end
          end
          default: begin
            state_d = WAIT_ST;
            ext_d   = 1'b0;
          end
        endcase
      end
    end else if (state_q == WAIT_ST) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      // Prefix left dangling: drop it, held keys are untouched.
      err_d   = 1'b1;
      ext_d   = 1'b0;
      cnt_d   = '0;
      state_d = WAIT_ST;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end

    if (complete) begin
      code_out_d   = {brk, ext_use, bus.din};
      code_valid_d = 1'b1;
      // Each key is matched independently, so aliased keys all update.
      for (int i = 0; i < 4; i++) begin
        if (bus.din == KEY_CODES[i] && ext_use == KEY_EXTS[i]) begin
          if (!brk && !key_down_q[i]) begin
            key_down_d[i]  = 1'b1;
            key_press_d[i] = 1'b1;
          end else if (brk && key_down_q[i]) begin
            key_down_d[i]    = 1'b0;
            key_release_d[i] = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= WAIT_ST;
      ext_q         <= 1'b0;
      cnt_q         <= '0;
      key_down_q    <= '0;
      key_press_q   <= '0;
      key_release_q <= '0;
      code_out_q    <= '0;
      code_valid_q  <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      ext_q         <= ext_d;
      cnt_q         <= cnt_d;
      key_down_q    <= key_down_d;
      key_press_q   <= key_press_d;
      key_release_q <= key_release_d;
      code_out_q    <= code_out_d;
      code_valid_q  <= code_valid_d;
      err_q         <= err_d;
    end
  end

  assign bus.key_down    = key_down_q;
  assign bus.key_press   = key_press_q;
  assign bus.key_release = key_release_q;
  assign bus.code_out    = code_out_q;
  assign bus.code_valid  = code_valid_q;
  assign bus.err         = err_q;
  assign bus.state_dbg   = state_q;

endmodule

// File: tb/tb_kbd_key_ctrl.sv
// tb_kbd_key_ctrl: directed bench for kbd_key_ctrl. Key 3 is configured as
// extended 0x74 and the timeout is shortened to 16 cycles.
module tb_kbd_key_ctrl;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  kbd_key_if bus ();

  kbd_key_ctrl #(
    .KEY3_CODE      (8'h74),
    .KEY3_EXT       (1'b1),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- scoreboard ----------------
  // Event word: {err, code_valid, code_out[9:0], key_press, key_release, key_down}
  logic [23:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic expect_ev(input logic e, input logic cv, input logic [9:0] code,
                           input logic [3:0] pr, input logic [3:0] rl,
                           input logic [3:0] dn);
    exp_q.push_back({e, cv, code, pr, rl, dn});
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    n_cmp++;
    if (got !== req) begin
      n_bad++;
      $display("FAIL %s got=%h required=%h", name, got, req);
    end
  endtask

  // Monitor: any pulse from the DUT is an event to be matched in order.
  always @(negedge clk) begin
    logic [23:0] got;
    logic [23:0] req;
    if (!reset && (bus.err || bus.code_valid || (|bus.key_press) || (|bus.key_release))) begin
      got = {bus.err, bus.code_valid, bus.code_out, bus.key_press, bus.key_release, bus.key_down};
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_event got=%h required=none", got);
      end else begin
        req = exp_q.pop_front();
        if (got !== req) begin
          n_bad++;
          $display("FAIL event got=%h required=%h", got, req);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [7:0] b);
    @(negedge clk);
    bus.din     = b;
    bus.din_new = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.din_new = 1'b0;
    end
  endtask

  task automatic send(input logic [7:0] b);
    drive(b);
    idle(1);
  endtask

  task automatic drain();
    bus.din_new = 1'b0;
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    check("drain", exp_q.size(), 0);
    idle(2);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.din     = 8'h00;
    bus.din_new = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    check("rst_key_down", bus.key_down, 4'h0);
    check("rst_code_out", bus.code_out, 10'h000);
    check("rst_code_valid", bus.code_valid, 1'b0);
    check("rst_err", bus.err, 1'b0);
    check("rst_pulses", {bus.key_press, bus.key_release}, 8'h00);
    check("rst_state", bus.state_dbg, 2'd0);

    // Make / break of key 0
    expect_ev(0, 1, 10'h012, 4'b0001, 4'b0000, 4'b0001);
    send(8'h12);
    expect_ev(0, 1, 10'h212, 4'b0000, 4'b0001, 4'b0000);
    send(8'hF0); send(8'h12);
    drain();

    // Typematic repeat of key 1
    expect_ev(0, 1, 10'h059, 4'b0010, 4'b0000, 4'b0010);
    expect_ev(0, 1, 10'h059, 4'b0000, 4'b0000, 4'b0010);
    expect_ev(0, 1, 10'h059, 4'b0000, 4'b0000, 4'b0010);
    send(8'h59); send(8'h59); send(8'h59);
    drain();

    // Extended key 3
    expect_ev(0, 1, 10'h074, 4'b0000, 4'b0000, 4'b0010);
    send(8'h74);
    expect_ev(0, 1, 10'h174, 4'b1000, 4'b0000, 4'b1010);
    send(8'hE0); send(8'h74);
    expect_ev(0, 1, 10'h374, 4'b0000, 4'b1000, 4'b0010);
    send(8'hE0); send(8'hF0); send(8'h74);
    expect_ev(0, 1, 10'h259, 4'b0000, 4'b0010, 4'b0000);
    send(8'hF0); send(8'h59);
    drain();

    // Dangling prefix times out; code_out keeps the last sequence
    expect_ev(1, 0, 10'h259, 4'b0000, 4'b0000, 4'b0000);
    drive(8'hE0); idle(16);
    drain();
    check("timeout_state", bus.state_dbg, 2'd0);
    expect_ev(0, 1, 10'h012, 4'b0001, 4'b0000, 4'b0001);
    send(8'h12);
    drain();

    // Noise bytes with keys 0 and 2 held
    expect_ev(0, 1, 10'h029, 4'b0100, 4'b0000, 4'b0101);
    send(8'h29);
    expect_ev(1, 0, 10'h029, 4'b0000, 4'b0000, 4'b0101);
    send(8'hFF);
    expect_ev(1, 0, 10'h029, 4'b0000, 4'b0000, 4'b0101);
    send(8'hE0); send(8'h00);
    drain();
    check("noise_key_down", bus.key_down, 4'b0101);

    // Break of an unheld key, then a bad byte after the break prefix
    expect_ev(0, 1, 10'h25A, 4'b0000, 4'b0000, 4'b0101);
    send(8'hF0); send(8'h5A);
    expect_ev(1, 0, 10'h25A, 4'b0000, 4'b0000, 4'b0101);
    send(8'hF0); send(8'hE0);
    drain();

    // Back-to-back strobes release key 2
    expect_ev(0, 1, 10'h229, 4'b0000, 4'b0100, 4'b0001);
    drive(8'hF0); drive(8'h29); idle(1);
    drain();

    // Byte arriving on the timeout cycle wins
    expect_ev(0, 1, 10'h112, 4'b0000, 4'b0000, 4'b0001);
    drive(8'hE0); idle(15); drive(8'h12); idle(1);
    drain();

    // Repeated 0xE0 restarts the timeout
    expect_ev(0, 1, 10'h159, 4'b0000, 4'b0000, 4'b0001);
    drive(8'hE0); idle(10); drive(8'hE0); idle(12); send(8'h59);
    drain();

    // Reset mid-sequence clears everything
    send(8'hE0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst_key_down", bus.key_down, 4'h0);
    check("midrst_code_out", bus.code_out, 10'h000);
    check("midrst_state", bus.state_dbg, 2'd0);
    reset = 1'b0;
    @(negedge clk);
    expect_ev(0, 1, 10'h029, 4'b0100, 4'b0000, 4'b0100);
    send(8'h29);
    drain();

    idle(5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
